// File: rtl/fifo_pkg.sv
// Shared types, sizing helpers and level/threshold comparisons for the
// single-clock FIFO flag controller.
package fifo_pkg;

  localparam int FIFO_ASIZE = 4;

  // Pointer for the default configuration: ASIZE address bits plus a wrap bit.
  typedef logic [FIFO_ASIZE:0] fifo_ptr_t;

  function automatic int fifo_depth(input int asize);
    return 1 << asize;
  endfunction

  function automatic logic level_at_or_above(input logic [31:0] lvl,
                                             input logic [31:0] thr);
    return (lvl >= thr);
  endfunction

  function automatic logic level_at_or_below(input logic [31:0] lvl,
                                             input logic [31:0] thr);
    return (lvl <= thr);
  endfunction

endpackage

// File: rtl/fifo_ptr_cnt.sv
// ASIZE+1-bit wrapping FIFO pointer; the MSB is the wrap bit.
module fifo_ptr_cnt
  import fifo_pkg::*;
#(
  parameter int ASIZE = FIFO_ASIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [ASIZE:0]   ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_sync_flag_ctrl.sv
// Single-clock FIFO pointer/flag controller for an external dual-port RAM.
// Define FIFO_STICKY_ERR_EN to make overflow/underflow sticky until clr_err.
module fifo_sync_flag_ctrl
  import fifo_pkg::*;
#(
  parameter int ASIZE      = FIFO_ASIZE,
  parameter int AFULL_DEF  = (2 ** ASIZE) - 2,
  parameter int AEMPTY_DEF = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [ASIZE:0]   afull_thr,
  input  logic             afull_thr_vld,
  input  logic [ASIZE:0]   aempty_thr,
  input  logic             aempty_thr_vld,
  input  logic             clr_err,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE-1:0] raddr,
  output logic             wr_acc,
  output logic             rd_acc,
  output logic             full,
  output logic             empty,
  output logic             afull,
  output logic             aempty,
  output logic [ASIZE:0]   level,
  output logic             overflow,
  output logic             underflow
);

  localparam int             DEPTH   = fifo_depth(ASIZE);
  localparam logic [ASIZE:0] DEPTH_V = (ASIZE+1)'(DEPTH);

  logic [ASIZE:0] wptr;
  logic [ASIZE:0] rptr;
  logic [ASIZE:0] level_n;
  logic [ASIZE:0] thr_a;
  logic [ASIZE:0] thr_e;
  logic           ovf_evt;
  logic           udf_evt;
  logic           unused_wrap;

  // Acceptance gates off the registered flags, so no fall-through when empty.
  assign wr_acc  = wr_en & ~full;
  assign rd_acc  = rd_en & ~empty;
  assign ovf_evt = wr_en & full;
  assign udf_evt = rd_en & empty;

  fifo_ptr_cnt #(.ASIZE(ASIZE)) u_wptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_acc),
    .ptr (wptr)
  );

  fifo_ptr_cnt #(.ASIZE(ASIZE)) u_rptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_acc),
    .ptr (rptr)
  );

  assign waddr       = wptr[ASIZE-1:0];
  assign raddr       = rptr[ASIZE-1:0];
  assign unused_wrap = wptr[ASIZE] ^ rptr[ASIZE];

  assign level_n = level + (ASIZE+1)'(wr_acc) - (ASIZE+1)'(rd_acc);
  assign thr_a   = afull_thr_vld  ? afull_thr  : (ASIZE+1)'(AFULL_DEF);
  assign thr_e   = aempty_thr_vld ? aempty_thr : (ASIZE+1)'(AEMPTY_DEF);

  // Flags are derived from next-state level, so they are exact one edge after the access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      afull  <= 1'b0;
      aempty <= 1'b1;
    end else begin
      level  <= level_n;
      full   <= (level_n == DEPTH_V);
      empty  <= (level_n == '0);
      afull  <= level_at_or_above(32'(level_n), 32'(thr_a));
      aempty <= level_at_or_below(32'(level_n), 32'(thr_e));
    end
  end

`ifdef FIFO_STICKY_ERR_EN
  // A new error in the same cycle as clr_err wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_evt | (overflow  & ~clr_err);
      underflow <= udf_evt | (underflow & ~clr_err);
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_evt;
      underflow <= udf_evt;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_flag_ctrl.sv
// Self-checking bench for fifo_sync_flag_ctrl using an occupancy-count model.
module tb_fifo_sync_flag_ctrl;

  localparam int ASIZE = 4;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en, rd_en, clr_err;
  logic [ASIZE:0]   afull_thr, aempty_thr;
  logic             afull_thr_vld, aempty_thr_vld;
  logic [ASIZE-1:0] waddr, raddr;
  logic             wr_acc, rd_acc, full, empty, afull, aempty;
  logic [ASIZE:0]   level;
  logic             overflow, underflow;

  fifo_sync_flag_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .rd_en          (rd_en),
    .afull_thr      (afull_thr),
    .afull_thr_vld  (afull_thr_vld),
    .aempty_thr     (aempty_thr),
    .aempty_thr_vld (aempty_thr_vld),
    .clr_err        (clr_err),
    .waddr          (waddr),
    .raddr          (raddr),
    .wr_acc         (wr_acc),
    .rd_acc         (rd_acc),
    .full           (full),
    .empty          (empty),
    .afull          (afull),
    .aempty         (aempty),
    .level          (level),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  // Reference model: occupancy, total accepted writes/reads, error flags.
  int   cnt, wtot, rtot, m_thra, m_thre;
  logic m_ovf, m_udf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cnt = 0; wtot = 0; rtot = 0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_level",  32'(level),     0);
    check("rst_empty",  32'(empty),     1);
    check("rst_aempty", 32'(aempty),    1);
    check("rst_full",   32'(full),      0);
    check("rst_afull",  32'(afull),     0);
    check("rst_ovf",    32'(overflow),  0);
    check("rst_udf",    32'(underflow), 0);
    check("rst_waddr",  32'(waddr),     0);
    check("rst_raddr",  32'(raddr),     0);
  endtask

  // Called at a falling edge: drive, check handshakes, clock, check registered state.
  task automatic step(input logic w, input logic r, input logic clr);
    logic wa, ra, ovf_evt, udf_evt;
    wr_en = w; rd_en = r; clr_err = clr;
    #1;
    wa      = w && (cnt < DEPTH);
    ra      = r && (cnt > 0);
    ovf_evt = w && (cnt == DEPTH);
    udf_evt = r && (cnt == 0);
    check("wr_acc", 32'(wr_acc), 32'(wa));
    check("rd_acc", 32'(rd_acc), 32'(ra));
    check("waddr",  32'(waddr),  wtot % DEPTH);
    check("raddr",  32'(raddr),  rtot % DEPTH);
    m_thra = afull_thr_vld  ? int'(afull_thr)  : DEPTH - 2;
    m_thre = aempty_thr_vld ? int'(aempty_thr) : 2;
    cnt  = cnt + int'(wa) - int'(ra);
    wtot = wtot + int'(wa);
    rtot = rtot + int'(ra);
`ifdef FIFO_STICKY_ERR_EN
    m_ovf = ovf_evt || (m_ovf && !clr);
    m_udf = udf_evt || (m_udf && !clr);
`else
    m_ovf = ovf_evt;
    m_udf = udf_evt;
`endif
    @(posedge clk);
    #1;
    check("level",     32'(level),     cnt);
    check("full",      32'(full),      32'(cnt == DEPTH));
    check("empty",     32'(empty),     32'(cnt == 0));
    check("afull",     32'(afull),     32'(cnt >= m_thra));
    check("aempty",    32'(aempty),    32'(cnt <= m_thre));
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_udf));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    afull_thr = '0; aempty_thr = '0; afull_thr_vld = 1'b0; aempty_thr_vld = 1'b0;
    model_reset();
    #3;
    check_reset_state();
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset mid-stream after five writes
    repeat (5) step(1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_reset_state();
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Fill to full, then one rejected write
    repeat (16) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    // Full with both requests: read only
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    // Drain to empty, then one rejected read
    repeat (16) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    // Empty with both requests: write only
    step(1'b1, 1'b1, 1'b0);

    // Wrap pointers at a steady level of 8
    repeat (7) step(1'b1, 1'b0, 1'b0);
    repeat (40) step(1'b1, 1'b1, 1'b0);

    // Runtime threshold change with no access
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    afull_thr = 5'd5; afull_thr_vld = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    aempty_thr = 5'd16; aempty_thr_vld = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    afull_thr = 5'd20;
    step(1'b1, 1'b0, 1'b0);
    afull_thr_vld = 1'b0; aempty_thr_vld = 1'b0;

    // Error flag persistence and clear
    repeat (11) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Randomized traffic with random thresholds and occasional clears
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        afull_thr      = 5'($urandom_range(0, 31));
        aempty_thr     = 5'($urandom_range(0, 31));
        afull_thr_vld  = 1'($urandom_range(0, 1));
        aempty_thr_vld = 1'($urandom_range(0, 1));
      end
      if (i < 200)
        step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 7) == 0));
      else
        step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_sync_flag_ctrl.md
Name: fifo_sync_flag_ctrl

Overview:
- Single-clock successor to the team's FIFO pointer comparator and direction-latch block.
- Owns the write and read pointers of a parametrised-depth RAM FIFO.
- Generates registered full/empty flags and programmable almost-full/almost-empty flags, plus a fill level and error reporting.
- Sits between the producer/consumer handshakes and a dual-port RAM; the RAM is external and addressed by waddr/raddr.

Parameters:
- ASIZE, 4, address width; FIFO depth DEPTH = 2**ASIZE entries.
- AFULL_DEF, 2**ASIZE-2, almost-full threshold used when afull_thr_vld=0.
- AEMPTY_DEF, 2, almost-empty threshold used when aempty_thr_vld=0.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- afull_thr  input  ASIZE+1  runtime almost-full threshold.
- afull_thr_vld  input  1  1 = use afull_thr; 0 = use AFULL_DEF.
- aempty_thr  input  ASIZE+1  runtime almost-empty threshold.
- aempty_thr_vld  input  1  1 = use aempty_thr; 0 = use AEMPTY_DEF.
- clr_err  input  1  clears the error flags.
- waddr  output  ASIZE  RAM write address.
- raddr  output  ASIZE  RAM read address.
- wr_acc  output  1  combinational; write accepted this cycle (drives RAM write enable).
- rd_acc  output  1  combinational; read accepted this cycle.
- full  output  1  registered; FIFO holds DEPTH entries.
- empty  output  1  registered; FIFO holds 0 entries.
- afull  output  1  registered; level >= effective afull threshold.
- aempty  output  1  registered; level <= effective aempty threshold.
- level  output  ASIZE+1  registered; current entry count, range 0..DEPTH.
- overflow  output  1  write attempted while full.
- underflow  output  1  read attempted while empty.

Behaviour:
- Reset is asynchronous on rst=1. Reset values: wptr=rptr=0, level=0, empty=1, aempty=1, full=0, afull=0, overflow=0, underflow=0.
- Internal pointers wptr/rptr are ASIZE+1 bits. The MSB is the wrap bit; waddr/raddr are the low ASIZE bits. Pointers wrap modulo 2**(ASIZE+1).
- Acceptance: wr_acc = wr_en & ~full; rd_acc = rd_en & ~empty. Both use the current registered flags.
- Each edge: wptr += wr_acc; rptr += rd_acc; level_n = level + wr_acc - rd_acc.
- Flags are computed from level_n and registered, so they are exact on the cycle after the access (zero-lag, no pessimism):
  - full <= (level_n == DEPTH); empty <= (level_n == 0).
  - afull <= (level_n >= thrA); aempty <= (level_n <= thrE), where thrA/thrE are the effective thresholds sampled that cycle.
  - A threshold change re-evaluates the flags at the next edge even with no access.
- Simultaneous wr_en and rd_en:
  - Neither full nor empty: both accepted; level unchanged.
  - When full: read accepted, write rejected; overflow set.
  - When empty: write accepted, read rejected; underflow set. No fall-through.
- Invariant: level == wptr - rptr (mod 2**(ASIZE+1)). full <=> pointers differ only in the MSB; empty <=> pointers are equal.
- Threshold out of range (> DEPTH): afull stays 0; aempty stays 1 whenever aempty_thr >= DEPTH.
- Error flags are set on wr_en & full or rd_en & empty. Without the optional feature they are single-cycle registered pulses (1 in the cycle after the attempt).
- rst asserted mid-transfer discards all contents immediately (asynchronous); the first accepted write after release goes to address 0.

Optional Feature:
- Macro FIFO_STICKY_ERR_EN.
- Defined: overflow/underflow are sticky. Once set they hold until clr_err=1 at an edge. If clr_err and a new error occur in the same cycle, set wins.
- Not defined: single-cycle pulses as described above; clr_err is ignored.

Decomposition:
- Shared package fifo_pkg holds:
  - Function for the level-to-flag comparisons.
  - Localparam helpers (DEPTH from ASIZE).
  - Typedef for the pointer type (logic [ASIZE:0]).
- One natural sub-module: fifo_ptr_cnt, the ASIZE+1-bit wrapping pointer with increment enable. Instantiate it twice (write and read).

Test Plan:
- Reset with rst=1 mid-stream after 5 writes -> level=0, empty=1, aempty=1, waddr=raddr=0 immediately, before any clock edge.
- ASIZE=4: 16 writes with no reads -> level=16, full=1; afull=1 from level 14 (default threshold); 17th wr_en -> wr_acc=0, overflow=1, wptr unchanged.
- Drain 16 reads -> empty=1 after the 16th; aempty=1 at level<=2; extra rd_en -> rd_acc=0, underflow=1.
- Full FIFO with wr_en=rd_en=1 for 1 cycle -> rd_acc=1, wr_acc=0, level=15, full=0 next cycle. Empty FIFO with both -> level=1, empty=0.
- Wrap: 40 cycles of simultaneous writes and reads at level 8 -> pointers wrap past 31 and 15; level stays 8; no flag glitches.
- Set afull_thr=5 with afull_thr_vld=1 at level 6 -> afull=1 next edge without any access. With FIFO_STICKY_ERR_EN: overflow holds until clr_err=1.
